// File: rtl/c_rx_pkg.sv
// c_rx_pkg: shared state encoding and default sizes for the C-element receive bridge
package c_rx_pkg;
    typedef enum logic [1:0] {IDLE, HOLD, ACK, WAIT_HIGH} state_t;
    localparam int DW_DEF    = 16;
    localparam int DEPTH_DEF = 4;
    localparam int SYNC_DEF  = 2;
    localparam int ACK_DEF   = 2;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop synchroniser with a configurable reset value
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_q <= {STAGES{RST_VAL}};
        else        r_q <= {r_q[STAGES-2:0], i_d};
    assign o_q = r_q[STAGES-1];
endmodule

// File: rtl/c_rx_sync.sv
// c_rx_sync: C-element Send/Ack receiver feeding a valid/ready FIFO; C_RX_ERRCNT_EN enables the protocol-error counter
module c_rx_sync import c_rx_pkg::*; #(
    parameter int DW          = DW_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int SYNC_STAGES = SYNC_DEF,
    parameter int ACK_CYCLES  = ACK_DEF
) (
    input  logic          CLK,
    input  logic          MR_n,
    input  logic          Send_in,
    input  logic [DW-1:0] Data_in,
    output logic          Ack_out,
    output logic [DW-1:0] Dout,
    output logic          Valid,
    input  logic          Ready,
    output logic [7:0]    Err_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(ACK_CYCLES + 1);
    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_ack_n, r_s_d, w_s, w_live, w_fall;
    logic [PW:0]     r_wr, r_rd, w_fill;
    logic [PW-1:0]   w_rd_nxt;
    logic [DW-1:0]   r_mem [DEPTH];
    logic [DW-1:0]   r_dout;
    logic            w_full, w_pop, w_space, w_wr, w_empty_after;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (.clk(CLK), .rst_n(MR_n), .i_d(Send_in), .o_q(w_s));
    // s_d stays 0 until the reset ones have flushed out, so a request held low across reset is not a fall
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_live (.clk(CLK), .rst_n(MR_n), .i_d(1'b1), .o_q(w_live));

    assign w_fall        = r_s_d && !w_s;
    assign Valid         = r_wr != r_rd;
    assign w_full        = (r_wr[PW] != r_rd[PW]) && (r_wr[PW-1:0] == r_rd[PW-1:0]);
    assign w_pop         = Valid && Ready;
    assign w_space       = !w_full || w_pop;
    assign w_fill        = r_wr - r_rd;
    assign w_empty_after = w_pop ? (w_fill == {{PW{1'b0}}, 1'b1}) : !Valid;
    assign w_rd_nxt      = r_rd[PW-1:0] + 1'b1;
    assign Ack_out       = r_ack_n;
    assign Dout          = r_dout;

    always_ff @(posedge CLK or negedge MR_n)
        if (!MR_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ack_n <= 1'b1;
            r_s_d   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == ACK) ? r_cnt + 1'b1 : '0;
            r_ack_n <= r_state != ACK;
            r_s_d   <= w_s && w_live;
        end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_fall) w_next = w_space ? ACK : HOLD;
            HOLD:    w_next = w_s ? IDLE : (w_space ? ACK : HOLD);
            ACK:     if (r_cnt == CW'(ACK_CYCLES - 1)) w_next = WAIT_HIGH;
            default: if (w_s) w_next = IDLE;
        endcase
    end

    always_comb begin
        w_wr = w_space && ((r_state == IDLE && w_fall) || (r_state == HOLD && !w_s));
    end

    always_ff @(posedge CLK or negedge MR_n)
        if (!MR_n) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_dout <= '0;
        end else begin
            if (w_wr) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            if (w_wr && w_empty_after) r_dout <= Data_in;
            else if (w_pop && !w_empty_after) r_dout <= r_mem[w_rd_nxt];
        end

    always_ff @(posedge CLK)
        if (w_wr) r_mem[r_wr[PW-1:0]] <= Data_in;

`ifdef C_RX_ERRCNT_EN
    logic       w_err;
    logic [7:0] r_err;
    assign w_err = (r_state == HOLD && w_s) || (r_state == ACK && w_s && !r_s_d) || (r_state == WAIT_HIGH && w_fall);
    always_ff @(posedge CLK or negedge MR_n)
        if (!MR_n) r_err <= '0;
        else if (w_err && r_err != 8'hFF) r_err <= r_err + 1'b1;
    assign Err_cnt = r_err;
`else
    assign Err_cnt = '0;
`endif
endmodule

// File: tb/tb_c_rx_sync.sv
// tb_c_rx_sync: directed handshakes against a queue-based timing model plus literal expectations
module tb_c_rx_sync;
    localparam int DW = 16, DEPTH = 4, SYNC = 2, ACKC = 2;
`ifdef C_RX_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    logic          CLK = 1'b0, MR_n = 1'b0, Send_in = 1'b1, Ready = 1'b0;
    logic [DW-1:0] Data_in = '0, Dout;
    logic          Ack_out, Valid;
    logic [7:0]    Err_cnt;
    int            checks = 0, errors = 0;

    c_rx_sync #(.DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .ACK_CYCLES(ACKC)) dut (
        .CLK(CLK), .MR_n(MR_n), .Send_in(Send_in), .Data_in(Data_in), .Ack_out(Ack_out),
        .Dout(Dout), .Valid(Valid), .Ready(Ready), .Err_cnt(Err_cnt));

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: Send_in samples per edge, queue FIFO, handshake phase counters
    bit            m_samp[$];
    logic [DW-1:0] m_q[$];
    int            m_ack_left = 0, m_err = 0;
    bit            m_pend = 0, m_wait = 0, m_ack = 1;
    logic [DW-1:0] m_dout = '0;

    always @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            m_samp.delete(); m_q.delete();
            m_ack_left = 0; m_pend = 0; m_wait = 0; m_ack = 1; m_dout = '0; m_err = 0;
        end else begin
            int k;
            bit s, sd, fall, rise, pop, space, wr, err;
            k = m_samp.size();
            s = (k >= SYNC) ? m_samp[k-SYNC] : 1'b1;
            sd = (k >= SYNC + 1) ? m_samp[k-SYNC-1] : 1'b0;
            fall = sd && !s;
            rise = s && !sd;
            pop = m_q.size() > 0 && Ready;
            space = m_q.size() < DEPTH || pop;
            wr = 0; err = 0;
            m_ack = (m_ack_left == 0);
            if (m_wait) begin
                err = fall;
                if (s) m_wait = 0;
            end else if (m_ack_left > 0) begin
                err = rise;
                m_ack_left--;
                if (m_ack_left == 0) m_wait = 1;
            end else if (m_pend) begin
                if (s) begin err = 1; m_pend = 0; end
                else if (space) begin wr = 1; m_pend = 0; end
            end else if (fall) begin
                if (space) wr = 1; else m_pend = 1;
            end
            if (wr) m_ack_left = ACKC;
            if (pop) void'(m_q.pop_front());
            if (wr) m_q.push_back(Data_in);
            if (m_q.size() > 0) m_dout = m_q[0];
            if (ERR_EN && err && m_err < 255) m_err++;
            m_samp.push_back(Send_in);
        end
    end

    always @(negedge CLK)
        if (MR_n) begin
            check("cyc_ack", 32'(Ack_out), 32'(m_ack));
            check("cyc_valid", 32'(Valid), 32'(m_q.size() > 0));
            check("cyc_dout", 32'(Dout), 32'(m_dout));
            check("cyc_err", 32'(Err_cnt), 32'(m_err));
        end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_ack(input logic lvl);
        for (int t = 0; t < 40 && Ack_out !== lvl; t++) @(negedge CLK);
        check("ack_wait", 32'(Ack_out), 32'(lvl));
    endtask

    task automatic hs(input logic [DW-1:0] d);
        Data_in = d;
        Send_in = 1'b0;
        wait_ack(1'b0);
        Send_in = 1'b1;
        wait_ack(1'b1);
        tick(3);
    endtask

    task automatic pop1;
        Ready = 1'b1;
        tick(1);
        Ready = 1'b0;
    endtask

    task automatic drain(input logic [DW-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            check("drain_valid", 32'(Valid), 32'd1);
            check("drain_dout", 32'(Dout), 32'(first + DW'(i)));
            pop1();
        end
        check("drain_empty", 32'(Valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("rst_ack", 32'(Ack_out), 32'd1);
        check("rst_valid", 32'(Valid), 32'd0);
        check("rst_err", 32'(Err_cnt), 32'd0);
        check("rst_dout", 32'(Dout), 32'd0);
        MR_n = 1'b1;
        tick(6);
        check("rel_nowrite", 32'(Valid), 32'd0);

        Data_in = 16'hA5C3;
        Send_in = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            check("lat_ack", 32'(Ack_out), 32'(!(i == 4 || i == 5)));
            if (i == 3) begin
                check("lat_valid", 32'(Valid), 32'd1);
                check("lat_dout", 32'(Dout), 32'hA5C3);
            end
            if (i == 4) Send_in = 1'b1;
        end
        tick(3);
        pop1();
        check("pop_empty", 32'(Valid), 32'd0);
        check("pop_hold_dout", 32'(Dout), 32'hA5C3);

        for (int d = 1; d <= 4; d++) hs(DW'(d));
        check("full_head", 32'(Dout), 32'd1);
        Data_in = 16'd5;
        Send_in = 1'b0;
        tick(8);
        check("hold_ack", 32'(Ack_out), 32'd1);
        pop1();
        check("hold_pop_head", 32'(Dout), 32'd2);
        wait_ack(1'b0);
        Send_in = 1'b1;
        wait_ack(1'b1);
        tick(3);
        drain(16'd2, 4);

        for (int d = 10; d <= 13; d++) hs(DW'(d));
        Data_in = 16'd14;
        Send_in = 1'b0;
        tick(2);
        Ready = 1'b1;
        tick(1);
        Ready = 1'b0;
        check("simul_head", 32'(Dout), 32'd11);
        wait_ack(1'b0);
        Send_in = 1'b1;
        wait_ack(1'b1);
        tick(3);
        drain(16'd11, 4);

        Data_in = 16'h0077;
        Send_in = 1'b0;
        tick(4);
        check("pre_rst_ack", 32'(Ack_out), 32'd0);
        check("pre_rst_valid", 32'(Valid), 32'd1);
        #2 MR_n = 1'b0;
        #1;
        check("mid_rst_ack", 32'(Ack_out), 32'd1);
        check("mid_rst_valid", 32'(Valid), 32'd0);
        @(negedge CLK);
        MR_n = 1'b1;
        tick(10);
        check("low_rel_valid", 32'(Valid), 32'd0);
        check("low_rel_ack", 32'(Ack_out), 32'd1);
        Send_in = 1'b1;
        tick(4);
        hs(16'h0088);
        check("post_rst_dout", 32'(Dout), 32'h0088);
        check("post_rst_valid", 32'(Valid), 32'd1);
        pop1();

        for (int d = 20; d <= 23; d++) hs(DW'(d));
        for (int n = 1; n <= 300; n++) begin
            Data_in = 16'hDEAD;
            Send_in = 1'b0;
            tick(7);
            Send_in = 1'b1;
            tick(6);
            if (n == 1) begin
                check("wd_err1", 32'(Err_cnt), ERR_EN ? 32'd1 : 32'd0);
                check("wd_head", 32'(Dout), 32'd20);
            end
        end
        check("wd_err_sat", 32'(Err_cnt), ERR_EN ? 32'd255 : 32'd0);
        drain(16'd20, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
